// File: rtl/audio_mon_pkg.sv
// Shared types and code-limit helpers for the audio sample monitor.
package audio_mon_pkg;

    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_ABS  = 2'd1,
        MODE_PEAK = 2'd2,
        MODE_CLIP = 2'd3
    } mode_e;

    // Two's complement extremes for a given width, returned in the low 'width' bits.
    function automatic logic [63:0] sample_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sample_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/abs_sat.sv
// Saturating magnitude of a two's complement sample; the most-negative code maps to max positive.
module abs_sat
    import audio_mon_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    localparam logic [W-1:0] MIN_CODE = W'(sample_min(W));
    localparam logic [W-1:0] MAX_CODE = W'(sample_max(W));

    always_comb begin
        y_o = x_i;
        if (x_i == MIN_CODE) begin
            y_o = MAX_CODE;
        end else if (x_i[W-1]) begin
            y_o = -x_i;
        end
    end

endmodule

// File: rtl/audio_sample_monitor.sv
// Codec strobe edge detect, display decimation, per-channel snapshot/peak/clip state,
// and a registered channel/mode selection for the seven-segment path.
module audio_sample_monitor
    import audio_mon_pkg::*;
#(
    parameter int SAMPLE_W    = 24,
    parameter int NUM_CH      = 2,
    parameter int DECIM       = 8192,
    parameter int DECAY_SHIFT = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       advance,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic [CH_W-1:0]            chan_sel,
    input  logic [1:0]                 mode,
    input  logic                       freeze,
    input  logic                       clip_clr,
    output logic [SAMPLE_W-1:0]        display_value,
    output logic                       update,
    output logic [NUM_CH-1:0]          clip
);

    localparam int                   CNT_W    = $clog2(DECIM);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [SAMPLE_W-1:0]  MAX_CODE = SAMPLE_W'(sample_max(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0]  MIN_CODE = SAMPLE_W'(sample_min(SAMPLE_W));

    logic             adv_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv_rise, tick, snap_en;

    assign adv_rise = advance & ~adv_q;
    assign tick     = adv_rise && (cnt_q == CNT_LAST);
    assign snap_en  = tick & ~freeze;

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (adv_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            adv_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            adv_q <= advance;
            cnt_q <= cnt_d;
        end
    end

    // Next-state views feed the display mux so the registered value lines up with update.
    logic [NUM_CH-1:0][SAMPLE_W-1:0] snap_d_w, peak_d_w;
    logic [NUM_CH-1:0]               clip_d_w, clip_q_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SAMPLE_W-1:0] smp, mag;
        logic [SAMPLE_W-1:0] snap_q, snap_d, peak_q, peak_d;
        logic                clip_q, clip_d;

        assign smp = sample_in[k*SAMPLE_W +: SAMPLE_W];

        abs_sat #(.W(SAMPLE_W)) u_abs (
            .x_i (smp),
            .y_o (mag)
        );

        always_comb begin
            snap_d = snap_q;
            peak_d = peak_q;
            clip_d = clip_q;
            if (snap_en) begin
                snap_d = smp;
            end
            if (adv_rise) begin
                if (mag > peak_q) begin
                    peak_d = mag;
                end else if (tick) begin
                    peak_d = peak_q - (peak_q >> DECAY_SHIFT);
                end
            end
            // A clipping strobe wins over a simultaneous clear.
            if (adv_rise && (smp == MAX_CODE || smp == MIN_CODE)) begin
                clip_d = 1'b1;
            end else if (clip_clr) begin
                clip_d = 1'b0;
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                snap_q <= '0;
                peak_q <= '0;
                clip_q <= 1'b0;
            end else begin
                snap_q <= snap_d;
                peak_q <= peak_d;
                clip_q <= clip_d;
            end
        end

        assign snap_d_w[k] = snap_d;
        assign peak_d_w[k] = peak_d;
        assign clip_d_w[k] = clip_d;
        assign clip_q_w[k] = clip_q;
    end

    logic [CH_W-1:0]     ch;
    logic [SAMPLE_W-1:0] disp_raw, disp_abs, disp_d, disp_q;
    logic                upd_q;

    assign ch       = (int'(chan_sel) < NUM_CH) ? chan_sel : '0;
    assign disp_raw = snap_d_w[ch];

    abs_sat #(.W(SAMPLE_W)) u_disp_abs (
        .x_i (disp_raw),
        .y_o (disp_abs)
    );

    always_comb begin
        disp_d = disp_raw;
        case (mode_e'(mode))
            MODE_RAW:  disp_d = disp_raw;
            MODE_ABS:  disp_d = disp_abs;
            MODE_PEAK: disp_d = peak_d_w[ch];
            MODE_CLIP: disp_d = SAMPLE_W'(clip_d_w);
            default:   disp_d = disp_raw;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            disp_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            upd_q  <= snap_en;
        end
    end

    assign display_value = disp_q;
    assign update        = upd_q;
    assign clip          = clip_q_w;

endmodule
